// File: rtl/soundrive_dac.sv
// Multi-channel Covox/Soundrive output stage.
// Decodes Z80 I/O writes into per-channel 8-bit samples, with an optional
// double-buffer reloaded at a fixed rate. Each sample drives a 1st- or
// 2nd-order sigma-delta PDM modulator.
module soundrive_dac #(
   parameter int         CHANNELS   = 4,
   parameter logic [7:0] PORT_BASE  = 8'h0F,
   parameter logic [7:0] PORT_STEP  = 8'h10,
   parameter logic [7:0] COVOX_PORT = 8'hFB,
   parameter int         ORDER      = 1,
   parameter int         LOAD_DIV   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          a,
   input  logic [7:0]          d,
   input  logic                n_wr,
   input  logic                n_m1,
   input  logic                n_iorq,
   output logic                port_hit,
   output logic [CHANNELS-1:0] dac
);

   logic                ioreq;
   logic                wr_lvl;
   logic                wr_prev;
   logic                wr_go;
   logic                covox_sel;
   logic [CHANNELS-1:0] ch_sel;

   assign ioreq     = !n_iorq && n_m1;
   assign wr_lvl    = ioreq && !n_wr;
   assign wr_go     = wr_lvl && !wr_prev;
   assign covox_sel = (a == COVOX_PORT);

   // Edge detect on the write strobe so a long /IORQ only commits once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_prev <= 1'b0;
      else     wr_prev <= wr_lvl;
   end

   // Address decode for the bus-control path; deliberately ignores ioreq.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) port_hit <= 1'b0;
      else     port_hit <= (|ch_sel) || covox_sel;
   end

   if (LOAD_DIV > 0) begin : g_ld
      localparam int DW = (LOAD_DIV > 1) ? $clog2(LOAD_DIV) : 1;
      logic [DW-1:0] div;
      logic          wrap;

      assign wrap = (div == DW'(LOAD_DIV - 1));

      // Free-running reload divider; wrap marks the shadow-to-active copy.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)       div <= '0;
         else if (wrap) div <= '0;
         else           div <= div + 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [7:0] CH_PORT = 8'(PORT_BASE + i * PORT_STEP);

      logic [7:0] shadow;
      logic [7:0] x;
      logic       dac_q;

      assign ch_sel[i] = (a == CH_PORT);
      assign dac[i]    = dac_q;

      // Sample capture from either the channel port or the broadcast port.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)                                   shadow <= 8'h00;
         else if (wr_go && (ch_sel[i] || covox_sel)) shadow <= d;
      end

      if (LOAD_DIV > 0) begin : g_active
         logic [7:0] active;

         // Reload on wrap; a commit on the same edge only reaches shadow.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)            active <= 8'h00;
            else if (g_ld.wrap) active <= shadow;
         end

         assign x = active;
      end else begin : g_direct
         assign x = shadow;
      end

      if (ORDER == 2) begin : g_o2
         logic signed [11:0] i1;
         logic signed [13:0] i2;
         logic signed [13:0] fb;
         logic signed [13:0] x_s;
         logic signed [13:0] i1n;
         logic signed [13:0] i2n;

         // Both integrators evaluated at 14 bits; i1 never exceeds 12 bits.
         always_comb begin
            fb  = dac_q ? 14'sd256 : 14'sd0;
            x_s = $signed({6'b000000, x});
            i1n = 14'(i1) + x_s - fb;
            i2n = i2 + i1n - fb;
         end

         // Integrator state; a zero sample parks the loop fully idle.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               i1    <= '0;
               i2    <= '0;
               dac_q <= 1'b0;
            end else if (x == 8'h00) begin
               i1    <= '0;
               i2    <= '0;
               dac_q <= 1'b0;
            end else begin
               i1    <= i1n[11:0];
               i2    <= i2n;
               dac_q <= ~i2n[13];
            end
         end
      end else begin : g_o1
         logic [8:0] acc;

         // Phase accumulator; the carry out is the PDM bit.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) acc <= 9'h000;
            else     acc <= {1'b0, acc[7:0]} + {1'b0, x};
         end

         assign dac_q = acc[8];
      end
   end

endmodule

// File: tb/tb_soundrive_dac.sv
// Bench for soundrive_dac: three instances share the Z80 bus and reset
// (1st order direct, 1st order with LOAD_DIV=16, 2nd order direct).
module tb_soundrive_dac;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a, d;
   logic       n_wr, n_m1, n_iorq;
   logic       hit0, hit_ld, hit_o2;
   logic [3:0] dac0, dac_ld, dac_o2;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc;
   int cnt [4];

   typedef struct packed {
      logic [7:0]      a;
      logic [7:0]      d;
      logic [3:0][8:0] exp;
   } wvec_t;

   typedef struct packed {
      logic [7:0] a;
      logic       exp;
   } hvec_t;

   wvec_t wv [6];
   hvec_t hv [10];

   always #5 clk = ~clk;

   soundrive_dac u0 (
      .clk(clk), .rst(rst), .a(a), .d(d), .n_wr(n_wr), .n_m1(n_m1),
      .n_iorq(n_iorq), .port_hit(hit0), .dac(dac0)
   );

   soundrive_dac #(.LOAD_DIV(16)) u_ld (
      .clk(clk), .rst(rst), .a(a), .d(d), .n_wr(n_wr), .n_m1(n_m1),
      .n_iorq(n_iorq), .port_hit(hit_ld), .dac(dac_ld)
   );

   soundrive_dac #(.ORDER(2)) u_o2 (
      .clk(clk), .rst(rst), .a(a), .d(d), .n_wr(n_wr), .n_m1(n_m1),
      .n_iorq(n_iorq), .port_hit(hit_o2), .dac(dac_o2)
   );

   // Clock edges since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_chk++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
   endtask

   function automatic wvec_t mk(input logic [7:0] aa, input logic [7:0] dd,
                                input int e0, input int e1, input int e2, input int e3);
      wvec_t r;
      r.a      = aa;
      r.d      = dd;
      r.exp[0] = 9'(e0);
      r.exp[1] = 9'(e1);
      r.exp[2] = 9'(e2);
      r.exp[3] = 9'(e3);
      return r;
   endfunction

   task automatic idle_bus();
      n_iorq = 1'b1;
      n_wr   = 1'b1;
      n_m1   = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_bus();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic goto_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   // Bus write driven at a negedge; the commit lands on the next posedge.
   task automatic wr(input logic [7:0] aa, input logic [7:0] dd);
      a      = aa;
      d      = dd;
      n_m1   = 1'b1;
      n_iorq = 1'b0;
      n_wr   = 1'b0;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic count256();
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      repeat (256) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) if (dac0[k]) cnt[k]++;
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int early, first_hi, mism, highs, viol, others;
      int m_i1, m_i2, m_dac, mx, f, n1, n2;

      wv[0] = mk(8'h1F, 8'h40,  0,  64,   0,   0);
      wv[1] = mk(8'hFB, 8'hC0, 192, 192, 192, 192);
      wv[2] = mk(8'h0F, 8'h10,  16, 192, 192, 192);
      wv[3] = mk(8'h3F, 8'hFF,  16, 192, 192, 255);
      wv[4] = mk(8'h4F, 8'h77,  16, 192, 192, 255);
      wv[5] = mk(8'h2F, 8'h00,  16, 192,   0, 255);

      hv[0] = '{8'h0F, 1'b1};
      hv[1] = '{8'h1F, 1'b1};
      hv[2] = '{8'h2F, 1'b1};
      hv[3] = '{8'h3F, 1'b1};
      hv[4] = '{8'hFB, 1'b1};
      hv[5] = '{8'h4F, 1'b0};
      hv[6] = '{8'h00, 1'b0};
      hv[7] = '{8'hFA, 1'b0};
      hv[8] = '{8'hFF, 1'b0};
      hv[9] = '{8'h0E, 1'b0};

      rst = 1'b1;
      a   = 8'h00;
      d   = 8'h00;
      idle_bus();
      do_reset();
      @(negedge clk);

      chk("rst_hit0",   int'(hit0),   0);
      chk("rst_hit_ld", int'(hit_ld), 0);
      chk("rst_hit_o2", int'(hit_o2), 0);
      chk("rst_dac0",   int'(dac0),   0);
      chk("rst_dac_ld", int'(dac_ld), 0);
      chk("rst_dac_o2", int'(dac_o2), 0);

      // port_hit decode table, bus idle
      for (int i = 0; i < 10; i++) begin
         a = hv[i].a;
         @(negedge clk);
         chk($sformatf("hit_%02h", hv[i].a), int'(hit0), int'(hv[i].exp));
      end

      // port_hit is registered: unchanged before the edge, set after it
      a = 8'h00;
      @(negedge clk);
      a = 8'h0F;
      #2;
      chk("hit_before_edge", int'(hit0), 0);
      @(negedge clk);
      chk("hit_after_edge", int'(hit0), 1);

      // cumulative write table, duty per 256 clocks on every channel
      for (int i = 0; i < 6; i++) begin
         wr(wv[i].a, wv[i].d);
         repeat (4) @(negedge clk);
         count256();
         for (int k = 0; k < 4; k++)
            chk($sformatf("wr%0d_ch%0d", i, k), cnt[k], int'(wv[i].exp[k]));
      end

      // long write, data changes after first clock: only 8'h20 is stored
      a      = 8'h2F;
      d      = 8'h20;
      n_m1   = 1'b1;
      n_iorq = 1'b0;
      n_wr   = 1'b0;
      @(negedge clk);
      d = 8'h80;
      repeat (5) @(negedge clk);
      idle_bus();
      repeat (4) @(negedge clk);
      count256();
      chk("hold_single_commit", cnt[2], 32);

      // interrupt acknowledge cycle must not commit
      a      = 8'h0F;
      d      = 8'hFF;
      n_m1   = 1'b0;
      n_iorq = 1'b0;
      n_wr   = 1'b0;
      repeat (3) @(negedge clk);
      idle_bus();
      repeat (4) @(negedge clk);
      count256();
      chk("intack_no_commit", cnt[0], 16);

      // read cycle: no commit, port still decoded
      a      = 8'h00;
      @(negedge clk);
      a      = 8'h0F;
      d      = 8'hFF;
      n_m1   = 1'b1;
      n_iorq = 1'b0;
      n_wr   = 1'b1;
      @(negedge clk);
      chk("read_hit", int'(hit0), 1);
      repeat (2) @(negedge clk);
      idle_bus();
      repeat (4) @(negedge clk);
      count256();
      chk("read_no_commit", cnt[0], 16);

      // LOAD_DIV=16: commit while div=3 (edge 4), wrap at edge 16
      do_reset();
      goto_cyc(3);
      wr(8'h0F, 8'hFF);
      early    = 0;
      first_hi = -1;
      while (cyc < 17) begin
         @(negedge clk);
         if (dac_ld[0]) early++;
         if (dac0[0] && first_hi < 0) first_hi = cyc;
      end
      chk("ld0_direct_latency", first_hi, 6);
      chk("ld_no_early_load", early, 0);
      @(negedge clk);
      chk("ld_wrap_load", int'(dac_ld[0]), 1);

      // commit landing on the wrap edge (32) waits for the wrap at 48
      goto_cyc(31);
      wr(8'h1F, 8'h80);
      early = 0;
      while (cyc < 49) begin
         @(negedge clk);
         if (dac_ld[1]) early++;
      end
      chk("ld_wrap_commit_deferred", early, 0);
      @(negedge clk);
      chk("ld_wrap_commit_next", int'(dac_ld[1]), 1);

      // ORDER=2 against a reference model of the modulator equations
      do_reset();
      wr(8'h0F, 8'h80);
      m_i1  = 0;
      m_i2  = 0;
      m_dac = 0;
      mx    = 128;
      mism  = 0;
      highs = 0;
      viol  = 0;
      others = 0;
      for (int n = 0; n < 4096; n++) begin
         f  = (m_dac != 0) ? 256 : 0;
         n1 = m_i1 + mx - f;
         n2 = m_i2 + n1 - f;
         if (mx == 0) begin
            m_i1 = 0; m_i2 = 0; m_dac = 0;
         end else begin
            m_i1 = n1; m_i2 = n2; m_dac = (n2 >= 0) ? 1 : 0;
         end
         if (m_i1 > 2047 || m_i1 < -2048 || m_i2 > 8191 || m_i2 < -8192) viol++;
         @(negedge clk);
         if (int'(dac_o2[0]) != m_dac) mism++;
         if (dac_o2[0]) highs++;
         if (dac_o2[3:1] != 3'b000) others++;
      end
      chk("o2_model_match", mism, 0);
      chk_rng("o2_duty_128", highs, 2046, 2050);
      chk("o2_range", viol, 0);
      chk("o2_idle_channels", others, 0);

      // reset mid-stream while the PDM bit is high
      for (int n = 0; n < 8 && !dac_o2[0]; n++) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_dac_o2", int'(dac_o2), 0);
      chk("midrst_dac0",   int'(dac0),   0);
      chk("midrst_hit",    int'(hit0),   0);
      @(negedge clk);
      rst = 1'b0;
      others = 0;
      repeat (300) begin
         @(negedge clk);
         if (dac_o2 != 4'h0 || dac0 != 4'h0 || dac_ld != 4'h0) others++;
      end
      chk("post_rst_silent", others, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
